// File: rtl/otp_verify_fsm.sv
// otp_verify_fsm: captures an OTP word, checks user nibble entries, tracks tries and lockout.
// Optional OTP expiry is built when OTP_TIMEOUT_EN is defined.
module otp_verify_fsm #(
    parameter int DIGITS      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1024,
    parameter int OTP_TTL     = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] otp_word,
    input  logic                otp_latch,
    input  logic [3:0]          user_in,
    input  logic                user_latch,
    output logic [2:0]          digit_cnt,
    output logic [2:0]          tries_left,
    output logic                pass,
    output logic                fail,
    output logic                locked,
    output logic                expired
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(W);
    localparam int LW = $clog2(LOCK_CYCLES);
    localparam logic [2:0]    TRIES_INIT = 3'(MAX_TRIES);
    localparam logic [3:0]    CNT_FULL   = 4'(DIGITS);
    localparam logic [LW-1:0] LOCK_INIT  = LW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ARMED, CHECK, PASS, LOCK} state_t;

    state_t        state, state_n;
    logic [W-1:0]  otp_reg, otp_n;
    logic [W-1:0]  entry, entry_n;
    logic [3:0]    cnt, cnt_n;
    logic [2:0]    tries_n;
    logic          pass_n, fail_n, locked_n;
    logic [LW-1:0] lock_cnt, lock_n;
    logic [IW-1:0] pos;
    logic          capture;

    logic [2:0] otp_sy, usr_sy;
    logic [3:0] nib_s1, nib_s2;
    logic [1:0] warm;
    logic       otp_edge, usr_edge;
    logic       timeout;

    // Edges are masked until the synchronizers have refilled after reset,
    // so a pin held high across reset release is not seen as a rise.
    assign otp_edge  = (warm == 2'd3) && otp_sy[1] && !otp_sy[2];
    assign usr_edge  = (warm == 2'd3) && usr_sy[1] && !usr_sy[2];
    assign digit_cnt = cnt[2:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            otp_sy <= '0;
            usr_sy <= '0;
            nib_s1 <= '0;
            nib_s2 <= '0;
            warm   <= '0;
        end else begin
            otp_sy <= {otp_sy[1:0], otp_latch};
            usr_sy <= {usr_sy[1:0], user_latch};
            nib_s1 <= user_in;
            nib_s2 <= nib_s1;
            if (warm != 2'd3) warm <= warm + 2'd1;
        end
    end

`ifdef OTP_TIMEOUT_EN
    localparam int TW = $clog2(OTP_TTL + 1);
    logic [TW-1:0] ttl, ttl_n;

    assign timeout = (state == ARMED) && (ttl == TW'(1));

    always_comb begin
        ttl_n = ttl;
        if (capture) ttl_n = TW'(OTP_TTL);
        else if (state == ARMED) ttl_n = ttl - TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ttl     <= '0;
            expired <= 1'b0;
        end else begin
            ttl     <= ttl_n;
            expired <= timeout;
        end
    end
`else
    // No TTL hardware: expiry can never fire.
    assign timeout = 1'b0;
    assign expired = (OTP_TTL < 0);
`endif

    always_comb begin
        state_n  = state;
        otp_n    = otp_reg;
        entry_n  = entry;
        cnt_n    = cnt;
        tries_n  = tries_left;
        pass_n   = pass;
        fail_n   = fail;
        locked_n = locked;
        lock_n   = lock_cnt;
        pos      = IW'(cnt) << 2;
        capture  = 1'b0;
        unique case (state)
            IDLE, PASS: capture = otp_edge;
            ARMED: begin
                if (timeout) begin
                    state_n = IDLE;
                    otp_n   = '0;
                    entry_n = '0;
                    cnt_n   = '0;
                    tries_n = TRIES_INIT;
                    fail_n  = 1'b0;
                end else if (otp_edge) begin
                    capture = 1'b1;
                end else if (usr_edge) begin
                    entry_n[pos +: 4] = nib_s2;
                    cnt_n  = cnt + 4'd1;
                    fail_n = 1'b0;
                    if (cnt_n == CNT_FULL) state_n = CHECK;
                end
            end
            CHECK: begin
                if (entry == otp_reg) begin
                    state_n = PASS;
                    pass_n  = 1'b1;
                end else begin
                    tries_n = tries_left - 3'd1;
                    fail_n  = 1'b1;
                    cnt_n   = '0;
                    entry_n = '0;
                    if (tries_n == 3'd0) begin
                        state_n  = LOCK;
                        locked_n = 1'b1;
                        lock_n   = LOCK_INIT;
                    end else begin
                        state_n = ARMED;
                    end
                end
            end
            LOCK: begin
                if (lock_cnt == '0) begin
                    state_n  = IDLE;
                    locked_n = 1'b0;
                    otp_n    = '0;
                    tries_n  = TRIES_INIT;
                    fail_n   = 1'b0;
                end else begin
                    lock_n = lock_cnt - LW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (capture) begin
            state_n = ARMED;
            otp_n   = otp_word;
            entry_n = '0;
            cnt_n   = '0;
            tries_n = TRIES_INIT;
            pass_n  = 1'b0;
            fail_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            otp_reg    <= '0;
            entry      <= '0;
            cnt        <= '0;
            tries_left <= TRIES_INIT;
            pass       <= 1'b0;
            fail       <= 1'b0;
            locked     <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            state      <= state_n;
            otp_reg    <= otp_n;
            entry      <= entry_n;
            cnt        <= cnt_n;
            tries_left <= tries_n;
            pass       <= pass_n;
            fail       <= fail_n;
            locked     <= locked_n;
            lock_cnt   <= lock_n;
        end
    end
endmodule

// File: tb/tb_otp_verify_fsm.sv
// tb_otp_verify_fsm: randomized and directed stimulus checked every cycle
// against a session-level model of the OTP verifier.
module tb_otp_verify_fsm;
    localparam int DIGITS      = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;
    localparam int OTP_TTL     = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] otp_word = '0;
    logic        otp_latch = 1'b0;
    logic [3:0]  user_in = '0;
    logic        user_latch = 1'b0;
    logic [2:0]  digit_cnt, tries_left;
    logic        pass, fail, locked, expired;

    always #5 clk = ~clk;

    otp_verify_fsm #(
        .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES),
        .LOCK_CYCLES(LOCK_CYCLES), .OTP_TTL(OTP_TTL)
    ) dut (
        .clk(clk), .reset(reset), .otp_word(otp_word),
        .otp_latch(otp_latch), .user_in(user_in),
        .user_latch(user_latch), .digit_cnt(digit_cnt),
        .tries_left(tries_left), .pass(pass), .fail(fail),
        .locked(locked), .expired(expired)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Session-level model: pin histories, digit queue, cycle deadlines.
    typedef struct packed { logic lvl; logic ok; logic [3:0] nib; } smp_t;
    smp_t        oh[$], uh[$];
    logic [3:0]  m_dig[$];
    logic [15:0] m_otp = '0;
    bit          m_have, m_passed, m_checking, m_fail, m_locked, m_exp;
    int          m_tries = MAX_TRIES;
    int          m_cyc = 0, m_lock_end = 0, m_ttl_end = 0;
    bit          run_cmp = 0;

    function automatic logic [15:0] packed_entry();
        logic [15:0] v = '0;
        foreach (m_dig[i]) v[4*i +: 4] = m_dig[i];
        return v;
    endfunction

    always @(posedge clk) begin
        bit oe, ue, armed;
        m_cyc++;
        m_exp = 0;
        if (!reset) begin
            oh.delete();
            uh.delete();
            repeat (4) begin
                oh.push_back('0);
                uh.push_back('0);
            end
            m_dig.delete();
            m_have = 0; m_passed = 0; m_checking = 0;
            m_fail = 0; m_locked = 0; m_tries = MAX_TRIES;
        end else begin
            oh.push_front({otp_latch, 1'b1, 4'h0});
            uh.push_front({user_latch, 1'b1, user_in});
            void'(oh.pop_back());
            void'(uh.pop_back());
            oe = oh[2].lvl && !oh[3].lvl && oh[3].ok;
            ue = uh[2].lvl && !uh[3].lvl && uh[3].ok;
            armed = m_have && !m_passed && !m_checking && !m_locked;
            if (m_locked) begin
                if (m_cyc == m_lock_end) begin
                    m_locked = 0; m_have = 0;
                    m_tries = MAX_TRIES; m_fail = 0;
                end
            end else if (m_checking) begin
                m_checking = 0;
                m_ttl_end++;
                if (packed_entry() == m_otp) begin
                    m_passed = 1;
                end else begin
                    m_tries--;
                    m_fail = 1;
                    m_dig.delete();
                    if (m_tries == 0) begin
                        m_locked = 1;
                        m_lock_end = m_cyc + LOCK_CYCLES;
                    end
                end
            end
`ifdef OTP_TIMEOUT_EN
            else if (armed && m_cyc == m_ttl_end) begin
                m_exp = 1; m_have = 0; m_dig.delete();
                m_tries = MAX_TRIES; m_fail = 0;
            end
`endif
            else if (oe) begin
                m_have = 1; m_passed = 0; m_fail = 0;
                m_dig.delete();
                m_tries = MAX_TRIES;
                m_otp = otp_word;
                m_ttl_end = m_cyc + OTP_TTL;
            end else if (ue && armed) begin
                m_dig.push_back(uh[2].nib);
                m_fail = 0;
                if (m_dig.size() == DIGITS) m_checking = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] exp_v, got_v;
        if (run_cmp) begin
            exp_v = {3'(m_dig.size()), 3'(m_tries), m_passed && m_have,
                     m_fail, m_locked, m_exp};
            got_v = {digit_cnt, tries_left, pass, fail, locked, expired};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL cycle %0d outputs: got cnt=%0d tries=%0d p=%b f=%b l=%b e=%b expected cnt=%0d tries=%0d p=%b f=%b l=%b e=%b",
                         m_cyc, got_v[9:7], got_v[6:4], got_v[3], got_v[2], got_v[1], got_v[0],
                         exp_v[9:7], exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_otp(logic [15:0] w);
        otp_word = w;
        otp_latch = 1'b1;
        cyc(3);
        otp_latch = 1'b0;
        cyc(3);
    endtask

    task automatic enter(logic [3:0] n);
        user_in = n;
        user_latch = 1'b1;
        cyc(3);
        user_latch = 1'b0;
        cyc(3);
    endtask

    task automatic do_reset(int n);
        reset = 1'b0;
        cyc(n);
        reset = 1'b1;
        cyc(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, e;
        cyc(1);
        run_cmp = 1;
        chk("reset_tries", tries_left, 3);
        chk("reset_cnt", digit_cnt, 0);
        do_reset(2);

        pulse_otp(16'hA5C3);
        enter(4'h3); enter(4'hC); enter(4'h5); enter(4'hA);
        chk("s1_pass", pass, 1);
        chk("s1_tries", tries_left, 3);

        pulse_otp(16'hA5C3);
        repeat (4) enter(4'h0);
        chk("s2_fail", fail, 1);
        chk("s2_tries2", tries_left, 2);
        repeat (4) enter(4'h0);
        chk("s2_tries1", tries_left, 1);
        enter(4'h3);
        chk("s2_fail_clr", fail, 0);
        chk("s2_cnt1", digit_cnt, 1);

        enter(4'h0); enter(4'h0);
        user_in = 4'h0;
        user_latch = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (locked) n++;
            if (i == 2) user_latch = 1'b0;
            if (i == 8) begin otp_latch = 1'b1; user_latch = 1'b1; end
            if (i == 11) begin otp_latch = 1'b0; user_latch = 1'b0; end
        end
        chk("s3_lock_len", n, 16);
        chk("s3_unlocked", locked, 0);
        chk("s3_tries", tries_left, 3);
        chk("s3_cnt", digit_cnt, 0);

        pulse_otp(16'h1234);
        enter(4'h1); enter(4'h2);
        chk("s4_cnt2", digit_cnt, 2);
        otp_word = 16'h4321;
        otp_latch = 1'b1;
        user_in = 4'h7;
        user_latch = 1'b1;
        cyc(3);
        otp_latch = 1'b0;
        user_latch = 1'b0;
        cyc(3);
        chk("s4_cnt0", digit_cnt, 0);
        enter(4'h1); enter(4'h2); enter(4'h3); enter(4'h4);
        chk("s4_recapture", pass, 1);

        pulse_otp(16'hBEEF);
        enter(4'hF); enter(4'hE);
        reset = 1'b0;
        otp_latch = 1'b1;
        cyc(1);
        chk("s5_cnt", digit_cnt, 0);
        reset = 1'b1;
        cyc(8);
        enter(4'h5);
        chk("s5_no_capture", digit_cnt, 0);
        otp_latch = 1'b0;
        cyc(4);

        pulse_otp(16'h0F0F);
        e = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (expired) e++;
        end
`ifdef OTP_TIMEOUT_EN
        chk("s6_expired_once", e, 1);
        enter(4'hF);
        chk("s6_ignored", digit_cnt, 0);
`else
        chk("s6_no_expiry", e, 0);
`endif

        for (int it = 0; it < 300; it++) begin
            int r, idx;
            logic [3:0] nib;
            r = $urandom_range(0, 19);
            if (r < 2) begin
                pulse_otp(16'($urandom));
            end else if (r < 14) begin
                idx = m_dig.size();
                nib = 4'($urandom);
                if (idx < DIGITS && $urandom_range(0, 2) != 0)
                    nib = m_otp[4*idx +: 4];
                enter(nib);
            end else if (r < 17) begin
                repeat (10) begin
                    otp_latch = ($urandom_range(0, 5) == 0);
                    user_latch = ($urandom_range(0, 2) == 0);
                    user_in = 4'($urandom);
                    otp_word = 16'($urandom);
                    cyc(1);
                end
                otp_latch = 1'b0;
                user_latch = 1'b0;
                cyc(3);
            end else if (r < 19) begin
                cyc($urandom_range(0, 20));
            end else begin
                reset = 1'b0;
                cyc($urandom_range(1, 2));
                reset = 1'b1;
                cyc(2);
            end
        end
        cyc(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
